// File: rtl/isa_bus_initiator.sv
// rtl/isa_bus_initiator.sv - ISA bus cycle generator (host end of the ISA slave interface)
//
// Turns a request/response handshake into one 8-bit IOR/IOW/MEMR/MEMW bus
// cycle: ADDR (ALE pulse) -> CMD (strobe low, wait/0WS/timeout) -> HOLD
// (response) -> RECOVER (bus idle) -> IDLE. Every output is registered.
//
// Ports:
//   clk, busreset               clock, synchronous active-high reset
//   req_valid/ready/write/io    request handshake and cycle type
//   req_addr[19:0], req_wdata   request address and write data
//   rsp_valid, rsp_rdata,       one-clock completion pulse, read data,
//   rsp_timeout                 timeout qualifier
//   bus_a, bus_ale, bus_aen     address, address latch enable, address enable
//   bus_*_l                     active-low command strobes
//   bus_d_out, bus_d_oe,        split data bus (the tristate lives on the board)
//   bus_d_in
//   bus_rdy, bus_0ws_l          wait-state request, zero-wait-state request
module isa_bus_initiator #(
  parameter int CMD_CYCLES = 4,
  parameter int RECOVERY   = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        busreset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_io,
  input  logic [19:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_timeout,
  output logic [19:0] bus_a,
  output logic        bus_ale,
  output logic        bus_aen,
  output logic        bus_ior_l,
  output logic        bus_iow_l,
  output logic        bus_memr_l,
  output logic        bus_memw_l,
  output logic [7:0]  bus_d_out,
  output logic        bus_d_oe,
  input  logic [7:0]  bus_d_in,
  input  logic        bus_rdy,
  input  logic        bus_0ws_l
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int RW = (RECOVERY > 1) ? $clog2(RECOVERY + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_CMD, S_HOLD, S_RECOVER} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rec_q, rec_d;
  logic          wr_q, wr_d;
  logic          io_q, io_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_rdata_q, rsp_rdata_d;
  logic          rsp_timeout_q, rsp_timeout_d;
  logic [19:0]   bus_a_q, bus_a_d;
  logic          bus_ale_q, bus_ale_d;
  logic          bus_aen_q, bus_aen_d;
  logic          bus_ior_l_q, bus_ior_l_d;
  logic          bus_iow_l_q, bus_iow_l_d;
  logic          bus_memr_l_q, bus_memr_l_d;
  logic          bus_memw_l_q, bus_memw_l_d;
  logic [7:0]    bus_d_out_q, bus_d_out_d;
  logic          bus_d_oe_q, bus_d_oe_d;

  logic end_normal, end_zws, end_tmo, cmd_exit, in_cycle, in_cmd;

  always_comb begin
    end_normal = (cnt_q >= CW'(CMD_CYCLES)) && bus_rdy;
    end_zws    = (cnt_q >= CW'(2)) && !bus_0ws_l && bus_rdy;
    // Timeout ends the cycle even when the slave is still holding rdy low.
    end_tmo    = (cnt_q == CW'(TIMEOUT));
    cmd_exit   = end_normal || end_zws || end_tmo;

    state_d       = state_q;
    cnt_d         = cnt_q;
    rec_d         = rec_q;
    wr_d          = wr_q;
    io_d          = io_q;
    bus_a_d       = bus_a_q;
    bus_d_out_d   = bus_d_out_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          wr_d    = req_write;
          io_d    = req_io;
          // I/O cycles only decode 16 address bits; keep the top nibble quiet.
          bus_a_d = req_io ? {4'h0, req_addr[15:0]} : req_addr;
          if (req_write) bus_d_out_d = req_wdata;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        cnt_d   = CW'(1);
        state_d = S_CMD;
      end
      S_CMD: begin
        if (cmd_exit) begin
          state_d       = S_HOLD;
          rsp_timeout_d = end_tmo;
          if (!wr_q) rsp_rdata_d = end_tmo ? 8'hFF : bus_d_in;
        end else begin
          // Not exiting implies cnt_q < TIMEOUT, so this cannot wrap.
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (RECOVERY == 0) begin
          state_d = S_IDLE;
        end else begin
          rec_d   = RW'(1);
          state_d = S_RECOVER;
        end
      end
      S_RECOVER: begin
        if (rec_q >= RW'(RECOVERY)) state_d = S_IDLE;
        else                        rec_d   = rec_q + RW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they change with the state register.
    in_cycle     = (state_d == S_ADDR) || (state_d == S_CMD) || (state_d == S_HOLD);
    in_cmd       = (state_d == S_CMD);
    req_ready_d  = (state_d == S_IDLE);
    rsp_valid_d  = (state_d == S_HOLD);
    bus_ale_d    = (state_d == S_ADDR);
    bus_aen_d    = !in_cycle;
    bus_d_oe_d   = in_cycle && wr_d;
    bus_ior_l_d  = !(in_cmd &&  io_d && !wr_d);
    bus_iow_l_d  = !(in_cmd &&  io_d &&  wr_d);
    bus_memr_l_d = !(in_cmd && !io_d && !wr_d);
    bus_memw_l_d = !(in_cmd && !io_d &&  wr_d);
  end

  always_ff @(posedge clk) begin
    if (busreset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      rec_q         <= '0;
      wr_q          <= 1'b0;
      io_q          <= 1'b0;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 8'hFF;
      rsp_timeout_q <= 1'b0;
      bus_a_q       <= '0;
      bus_ale_q     <= 1'b0;
      bus_aen_q     <= 1'b1;
      bus_ior_l_q   <= 1'b1;
      bus_iow_l_q   <= 1'b1;
      bus_memr_l_q  <= 1'b1;
      bus_memw_l_q  <= 1'b1;
      bus_d_out_q   <= '0;
      bus_d_oe_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rec_q         <= rec_d;
      wr_q          <= wr_d;
      io_q          <= io_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
      bus_a_q       <= bus_a_d;
      bus_ale_q     <= bus_ale_d;
      bus_aen_q     <= bus_aen_d;
      bus_ior_l_q   <= bus_ior_l_d;
      bus_iow_l_q   <= bus_iow_l_d;
      bus_memr_l_q  <= bus_memr_l_d;
      bus_memw_l_q  <= bus_memw_l_d;
      bus_d_out_q   <= bus_d_out_d;
      bus_d_oe_q    <= bus_d_oe_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;
  assign bus_a       = bus_a_q;
  assign bus_ale     = bus_ale_q;
  assign bus_aen     = bus_aen_q;
  assign bus_ior_l   = bus_ior_l_q;
  assign bus_iow_l   = bus_iow_l_q;
  assign bus_memr_l  = bus_memr_l_q;
  assign bus_memw_l  = bus_memw_l_q;
  assign bus_d_out   = bus_d_out_q;
  assign bus_d_oe    = bus_d_oe_q;

endmodule

// File: tb/tb_isa_bus_initiator.sv
// tb/tb_isa_bus_initiator.sv - directed self-checking bench for isa_bus_initiator
module tb_isa_bus_initiator;

  logic        clk;
  logic        busreset;
  logic        req_valid, req_ready, req_write, req_io;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_timeout;
  logic [7:0]  rsp_rdata;
  logic [19:0] bus_a;
  logic        bus_ale, bus_aen;
  logic        bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l;
  logic [7:0]  bus_d_out, bus_d_in;
  logic        bus_d_oe, bus_rdy, bus_0ws_l;

  isa_bus_initiator dut (
    .clk(clk), .busreset(busreset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_io(req_io),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .bus_a(bus_a), .bus_ale(bus_ale), .bus_aen(bus_aen),
    .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l), .bus_memr_l(bus_memr_l), .bus_memw_l(bus_memw_l),
    .bus_d_out(bus_d_out), .bus_d_oe(bus_d_oe), .bus_d_in(bus_d_in),
    .bus_rdy(bus_rdy), .bus_0ws_l(bus_0ws_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int viol  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus rules: never two strobes low, never ALE together with a strobe.
  always @(negedge clk) begin
    if (!busreset) begin
      if ($countones({~bus_ior_l, ~bus_iow_l, ~bus_memr_l, ~bus_memw_l}) > 1) viol++;
      if (bus_ale && !(bus_ior_l && bus_iow_l && bus_memr_l && bus_memw_l)) viol++;
    end
  end

  // Labels: lbl = k means the value a sampler sees at handshake edge N + k.
  int         r_stb, r_bad, r_ale, r_busbad, r_off, r_after, r_rdy_off;
  logic [7:0] r_rdata;
  logic       r_tmo;

  task automatic do_cycle(input logic wr, input logic io, input logic [19:0] addr,
                          input logic [7:0] wd, input logic [7:0] din,
                          input int lo_from, input int lo_to, input logic zws);
    int         lbl, t;
    logic [3:0] want, stb;
    logic [19:0] exp_a;
    exp_a = io ? {4'h0, addr[15:0]} : addr;
    want  = {~io & wr, ~io & ~wr, io & wr, io & ~wr};
    r_stb = 0; r_bad = 0; r_ale = 0; r_busbad = 0; r_off = 0; r_after = 0; r_rdy_off = 0;
    r_rdata = 8'h00; r_tmo = 1'b0;
    bus_d_in = din; bus_0ws_l = ~zws; bus_rdy = 1'b1;
    req_valid = 1'b1; req_write = wr; req_io = io; req_addr = addr; req_wdata = wd;
    t = 0;
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    if (!req_ready) begin
      check("handshake_wait", 0, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    // Scramble the request pins: the latched cycle must not follow them.
    req_valid = 1'b0; req_addr = ~addr; req_wdata = ~wd; req_write = ~wr; req_io = ~io;
    lbl = 1;
    while (lbl <= 100) begin
      stb = {~bus_memw_l, ~bus_memr_l, ~bus_iow_l, ~bus_ior_l};
      if (stb != 4'h0) begin
        if (stb == want) r_stb++; else r_bad++;
      end
      if (bus_ale) r_ale++;
      if (bus_aen || bus_a != exp_a || bus_d_oe != wr || (wr && bus_d_out != wd)) r_busbad++;
      if (rsp_valid) begin
        r_off = lbl; r_rdata = rsp_rdata; r_tmo = rsp_timeout;
        break;
      end
      bus_rdy = (stb != 4'h0 && r_stb >= lo_from && r_stb <= lo_to) ? 1'b0 : 1'b1;
      @(negedge clk); lbl++;
    end
    bus_rdy = 1'b1; bus_0ws_l = 1'b1;
    if (r_off == 0) begin
      check("rsp_wait", 0, 1);
      return;
    end
    @(negedge clk); lbl++;
    r_after = rsp_valid;
    while (!req_ready && lbl < 120) begin @(negedge clk); lbl++; end
    r_rdy_off = lbl;
  endtask

  int lbl, hold_lbl, hs2_lbl, ales, seen, b2b_data_ok;

  initial begin
    busreset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_io = 1'b0;
    req_addr = '0; req_wdata = '0; bus_d_in = '0; bus_rdy = 1'b1; bus_0ws_l = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_strobes", {bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l}, 4'hF);
    check("rst_ale_aen_oe", {bus_ale, bus_aen, bus_d_oe}, 3'b010);
    check("rst_bus_a", bus_a, 20'h0);
    check("rst_d_out", bus_d_out, 8'h00);
    check("rst_ready", req_ready, 1'b0);
    check("rst_rsp", {rsp_valid, rsp_timeout}, 2'b00);
    check("rst_rdata", rsp_rdata, 8'hFF);
    busreset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", req_ready, 1'b1);

    // I/O write 0x3D9 <- 0x3F, no waits.
    do_cycle(1'b1, 1'b1, 20'h003D9, 8'h3F, 8'h00, 0, 0, 1'b0);
    check("iow_low_clocks", r_stb, 4);
    check("iow_wrong_strobe", r_bad, 0);
    check("iow_ale_pulses", r_ale, 1);
    check("iow_bus_hold", r_busbad, 0);
    check("iow_rsp_label", r_off, 6);
    check("iow_timeout", r_tmo, 1'b0);
    check("iow_rdata_kept", r_rdata, 8'hFF);
    check("iow_rsp_one_clk", r_after, 0);
    check("iow_ready_label", r_rdy_off, 9);

    // Memory read 0xB8000, rdy low for cnt 3..6.
    do_cycle(1'b0, 1'b0, 20'hB8000, 8'h00, 8'h41, 3, 6, 1'b0);
    check("memr_low_clocks", r_stb, 7);
    check("memr_wrong_strobe", r_bad, 0);
    check("memr_bus_hold", r_busbad, 0);
    check("memr_rsp_label", r_off, 9);
    check("memr_rdata", r_rdata, 8'h41);
    check("memr_timeout", r_tmo, 1'b0);

    // Memory write with 0WS from the first CMD clock.
    do_cycle(1'b1, 1'b0, 20'hA0123, 8'h5A, 8'h00, 0, 0, 1'b1);
    check("memw_low_clocks", r_stb, 2);
    check("memw_wrong_strobe", r_bad, 0);
    check("memw_bus_hold", r_busbad, 0);
    check("memw_rsp_label", r_off, 4);
    check("memw_rdata_kept", r_rdata, 8'h41);

    // I/O read with rdy stuck low -> timeout.
    do_cycle(1'b0, 1'b1, 20'h003DA, 8'h00, 8'h77, 1, 1000, 1'b0);
    check("tmo_low_clocks", r_stb, 64);
    check("tmo_rsp_label", r_off, 66);
    check("tmo_flag", r_tmo, 1'b1);
    check("tmo_rdata", r_rdata, 8'hFF);

    // Next request still works; upper address nibble cleared for I/O.
    do_cycle(1'b0, 1'b1, 20'hF03DA, 8'h00, 8'h09, 0, 0, 1'b0);
    check("post_tmo_low_clocks", r_stb, 4);
    check("post_tmo_ior", r_bad, 0);
    check("post_tmo_bus_hold", r_busbad, 0);
    check("post_tmo_rdata", r_rdata, 8'h09);
    check("post_tmo_flag", r_tmo, 1'b0);

    // Back-to-back with req_valid held high.
    req_valid = 1'b1; req_write = 1'b1; req_io = 1'b1; req_addr = 20'h003D8; req_wdata = 8'h11;
    lbl = 0;
    while (!req_ready && lbl < 20) begin @(negedge clk); lbl++; end
    check("b2b_first_ready", req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    req_addr = 20'h003D9; req_wdata = 8'h22;
    lbl = 1; hold_lbl = 0; hs2_lbl = 0; ales = 0;
    while (lbl < 40 && hs2_lbl == 0) begin
      if (bus_ale) ales++;
      if (rsp_valid && hold_lbl == 0) hold_lbl = lbl;
      if (req_ready) hs2_lbl = lbl;
      else begin @(negedge clk); lbl++; end
    end
    check("b2b_second_hs_gap", hs2_lbl - hold_lbl, 3);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    seen = 0; b2b_data_ok = 0; lbl = 0;
    while (seen == 0 && lbl < 40) begin
      if (bus_ale) begin
        ales++;
        if (bus_a == 20'h003D9 && bus_d_out == 8'h22 && bus_d_oe) b2b_data_ok = 1;
      end
      if (rsp_valid) seen = 1;
      else begin @(negedge clk); lbl++; end
    end
    check("b2b_second_rsp", seen, 1);
    check("b2b_ale_pulses", ales, 2);
    check("b2b_second_data", b2b_data_ok, 1);
    repeat (4) @(negedge clk);

    // busreset in the middle of CMD of a write.
    req_valid = 1'b1; req_write = 1'b1; req_io = 1'b1; req_addr = 20'h003B4; req_wdata = 8'hC3;
    lbl = 0;
    while (!req_ready && lbl < 20) begin @(negedge clk); lbl++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_iow_low", bus_iow_l, 1'b0);
    busreset = 1'b1;
    @(negedge clk);
    check("midrst_strobes", {bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l}, 4'hF);
    check("midrst_aen_oe_ale", {bus_aen, bus_d_oe, bus_ale}, 3'b100);
    check("midrst_rsp", rsp_valid, 1'b0);
    check("midrst_rdata", rsp_rdata, 8'hFF);
    busreset = 1'b0;
    @(negedge clk);
    check("midrst_ready", req_ready, 1'b1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    check("midrst_no_rsp", seen, 0);

    check("bus_rules", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench time limit");
  end

endmodule
